// File: rtl/sys_defs.sv
// Shared core definitions: ROB geometry and functional-unit scheduler state encoding.
package sys_defs;

  localparam int SYS_ROB_IDX_W = 5;
  localparam int SYS_ROB_DEPTH = 1 << SYS_ROB_IDX_W;

  typedef enum logic {
    FUS_IDLE = 1'b0,
    FUS_BUSY = 1'b1
  } fus_state_e;

endpackage

// File: rtl/rob_age_pick.sv
// Picks the oldest eligible request by ROB age relative to the head (wrap-aware).
// Ties go to the lower slot index. Purely combinational.
module rob_age_pick #(
  parameter int NUM_REQ   = 2,
  parameter int ROB_IDX_W = 5
) (
  input  logic [NUM_REQ-1:0]           eligible,
  input  logic [NUM_REQ*ROB_IDX_W-1:0] tags,
  input  logic [ROB_IDX_W-1:0]         head,
  output logic [NUM_REQ-1:0]           winner_oh,
  output logic                         any_valid
);

  logic [ROB_IDX_W-1:0] age;
  logic [ROB_IDX_W-1:0] best_age;

  // NOTE: blocking assignments are correct here: this is combinational logic
  // where each loop iteration must see the previous iteration's best_age.
  always_comb begin
    winner_oh = '0;
    any_valid = 1'b0;
    best_age  = '0;
    age       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Modular subtraction makes the age wrap-aware around the ROB end.
      age = tags[i*ROB_IDX_W +: ROB_IDX_W] - head;
      if (eligible[i] && (!any_valid || age < best_age)) begin
        winner_oh    = '0;
        winner_oh[i] = 1'b1;
        best_age     = age;
        any_valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fu_beq_sched.sv
// Issue scheduler for the branch FU: oldest-ready pick, busy tracking with
// back-to-back issue, squash recovery and a watchdog for a hung FU.
module fu_beq_sched
  import sys_defs::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ROB_IDX_W = SYS_ROB_IDX_W,
  parameter int TIMEOUT   = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         squash,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob_idx,
  input  logic [ROB_IDX_W-1:0]         rob_head,
  input  logic                         fu_done,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         fu_issue,
  output logic                         fu_busy,
  output logic [ROB_IDX_W-1:0]         issued_rob_idx,
  output logic                         proto_err,
  output logic [15:0]                  issue_cnt
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);

  fus_state_e           state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [ROB_IDX_W-1:0] issued_rob_idx_q, issued_rob_idx_d;
  logic                 proto_err_q, proto_err_d;
  logic [15:0]          issue_cnt_q, issue_cnt_d;

  logic [NUM_REQ-1:0]   pick_oh;
  logic                 pick_any;
  logic                 can_issue;
  logic [ROB_IDX_W-1:0] issue_tag;

  rob_age_pick #(
    .NUM_REQ  (NUM_REQ),
    .ROB_IDX_W(ROB_IDX_W)
  ) u_pick (
    .eligible (req_valid & req_ready),
    .tags     (req_rob_idx),
    .head     (rob_head),
    .winner_oh(pick_oh),
    .any_valid(pick_any)
  );

  // The FU is free now, or frees this cycle (back-to-back issue).
  assign can_issue = !reset && !squash && ((state_q == FUS_IDLE) || fu_done);
  assign grant     = can_issue ? pick_oh : '0;
  assign fu_issue  = can_issue && pick_any;

  always_comb begin
    issue_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) issue_tag = req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
    end
  end

  always_comb begin
    state_d          = state_q;
    timer_d          = timer_q;
    issued_rob_idx_d = issued_rob_idx_q;
    proto_err_d      = proto_err_q;
    issue_cnt_d      = issue_cnt_q;

    if (fu_issue) issue_cnt_d = issue_cnt_q + 16'd1;

    if (squash) begin
      state_d          = FUS_IDLE;
      timer_d          = '0;
      issued_rob_idx_d = '0;
    end else begin
      unique case (state_q)
        FUS_IDLE: begin
          timer_d = '0;
          if (fu_done) proto_err_d = 1'b1;
          if (fu_issue) begin
            state_d          = FUS_BUSY;
            issued_rob_idx_d = issue_tag;
          end
        end
        FUS_BUSY: begin
          if (fu_issue) begin
            timer_d          = '0;
            issued_rob_idx_d = issue_tag;
          end else if (fu_done) begin
            state_d = FUS_IDLE;
            timer_d = '0;
          end else if (timer_q == TMR_MAX) begin
            state_d     = FUS_IDLE;
            timer_d     = '0;
            proto_err_d = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = FUS_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= FUS_IDLE;
      timer_q          <= '0;
      issued_rob_idx_q <= '0;
      proto_err_q      <= 1'b0;
      issue_cnt_q      <= '0;
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      issued_rob_idx_q <= issued_rob_idx_d;
      proto_err_q      <= proto_err_d;
      issue_cnt_q      <= issue_cnt_d;
    end
  end

  assign fu_busy        = (state_q == FUS_BUSY);
  assign issued_rob_idx = issued_rob_idx_q;
  assign proto_err      = proto_err_q;
  assign issue_cnt      = issue_cnt_q;

endmodule

// File: tb/tb_fu_beq_sched.sv
// Directed-vector bench for the branch FU scheduler.
module tb_fu_beq_sched;

  logic        clock;
  logic        reset;
  logic        squash;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_rob_idx;
  logic [4:0]  rob_head;
  logic        fu_done;
  logic [1:0]  grant;
  logic        fu_issue;
  logic        fu_busy;
  logic [4:0]  issued_rob_idx;
  logic        proto_err;
  logic [15:0] issue_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  fu_beq_sched #(.NUM_REQ(2), .ROB_IDX_W(5), .TIMEOUT(64)) dut (
    .clock         (clock),
    .reset         (reset),
    .squash        (squash),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_rob_idx   (req_rob_idx),
    .rob_head      (rob_head),
    .fu_done       (fu_done),
    .grant         (grant),
    .fu_issue      (fu_issue),
    .fu_busy       (fu_busy),
    .issued_rob_idx(issued_rob_idx),
    .proto_err     (proto_err),
    .issue_cnt     (issue_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    squash      = 1'b0;
    req_valid   = 2'b00;
    req_ready   = 2'b00;
    req_rob_idx = '0;
    rob_head    = '0;
    fu_done     = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    clear_inputs();
    req_valid   = 2'b11;
    req_ready   = 2'b11;
    req_rob_idx = {5'd2, 5'd1};
    tick();
    tick();
    checks++;
    if ({grant, fu_issue, fu_busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_grant got %b exp 0000", {grant, fu_issue, fu_busy});
    end
    reset = 1'b0;
    clear_inputs();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({grant, fu_issue, fu_busy, issued_rob_idx, proto_err, issue_cnt} !== 26'd0) begin
        errors++;
        $display("FAIL idle_outputs cyc %0d got grant=%b busy=%b idx=%0d perr=%b cnt=%0d exp all 0",
                 i, grant, fu_busy, issued_rob_idx, proto_err, issue_cnt);
      end
    end
  endtask

  task automatic test_oldest_pick();
    rob_head    = 5'd0;
    req_rob_idx = {5'd2, 5'd4};
    req_valid   = 2'b11;
    req_ready   = 2'b11;
    #1;
    checks++;
    if (grant !== 2'b10 || fu_issue !== 1'b1) begin
      errors++;
      $display("FAIL pick_grant got %b/%b exp 10/1", grant, fu_issue);
    end
    tick();
    exp_cnt++;
    clear_inputs();
    checks++;
    if (fu_busy !== 1'b1 || issued_rob_idx !== 5'd2 || issue_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL pick_busy got busy=%b idx=%0d cnt=%0d exp 1/2/%0d",
               fu_busy, issued_rob_idx, issue_cnt, exp_cnt);
    end
    fu_done = 1'b1;
    #1;
    checks++;
    if (grant !== 2'b00) begin
      errors++;
      $display("FAIL done_noreq_grant got %b exp 00", grant);
    end
    tick();
    fu_done = 1'b0;
    checks++;
    if (fu_busy !== 1'b0) begin
      errors++;
      $display("FAIL done_noreq_idle got busy=%b exp 0", fu_busy);
    end
  endtask

  task automatic test_back_to_back();
    rob_head    = 5'd30;
    req_rob_idx = {5'd31, 5'd1};
    req_valid   = 2'b11;
    req_ready   = 2'b11;
    #1;
    checks++;
    if (grant !== 2'b10) begin
      errors++;
      $display("FAIL wrap_grant got %b exp 10", grant);
    end
    tick();
    exp_cnt++;
    req_valid = 2'b01;
    req_ready = 2'b01;
    fu_done   = 1'b1;
    #1;
    checks++;
    if (grant !== 2'b01 || fu_issue !== 1'b1) begin
      errors++;
      $display("FAIL b2b_grant got %b/%b exp 01/1", grant, fu_issue);
    end
    tick();
    exp_cnt++;
    clear_inputs();
    checks++;
    if (fu_busy !== 1'b1 || issued_rob_idx !== 5'd1 || issue_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL b2b_busy got busy=%b idx=%0d cnt=%0d exp 1/1/%0d",
               fu_busy, issued_rob_idx, issue_cnt, exp_cnt);
    end
    fu_done = 1'b1;
    tick();
    fu_done = 1'b0;
  endtask

  task automatic test_squash();
    req_rob_idx = {5'd5, 5'd3};
    req_valid   = 2'b01;
    req_ready   = 2'b01;
    #1;
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL sq_pre_grant got %b exp 01", grant);
    end
    tick();
    exp_cnt++;
    squash    = 1'b1;
    req_valid = 2'b10;
    req_ready = 2'b10;
    #1;
    checks++;
    if (grant !== 2'b00 || fu_issue !== 1'b0) begin
      errors++;
      $display("FAIL sq_grant got %b/%b exp 00/0", grant, fu_issue);
    end
    tick();
    clear_inputs();
    checks++;
    if (fu_busy !== 1'b0 || issued_rob_idx !== 5'd0 || issue_cnt !== 16'(exp_cnt) || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL sq_after got busy=%b idx=%0d cnt=%0d perr=%b exp 0/0/%0d/0",
               fu_busy, issued_rob_idx, issue_cnt, proto_err, exp_cnt);
    end
  endtask

  task automatic test_ready_rise();
    req_rob_idx = {5'd0, 5'd7};
    req_valid   = 2'b01;
    req_ready   = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (grant !== 2'b00) begin
        errors++;
        $display("FAIL notready_grant cyc %0d got %b exp 00", i, grant);
      end
      tick();
    end
    req_ready = 2'b01;
    #1;
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL ready_rise_grant got %b exp 01", grant);
    end
    tick();
    exp_cnt++;
    clear_inputs();
    checks++;
    if (fu_busy !== 1'b1 || issued_rob_idx !== 5'd7) begin
      errors++;
      $display("FAIL ready_rise_busy got busy=%b idx=%0d exp 1/7", fu_busy, issued_rob_idx);
    end
    fu_done = 1'b1;
    tick();
    fu_done = 1'b0;
  endtask

  task automatic test_timeout();
    req_rob_idx = {5'd0, 5'd9};
    req_valid   = 2'b01;
    req_ready   = 2'b01;
    #1;
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL to_grant got %b exp 01", grant);
    end
    tick();
    exp_cnt++;
    clear_inputs();
    for (int i = 1; i <= 64; i++) begin
      checks++;
      if (fu_busy !== 1'b1 || proto_err !== 1'b0) begin
        errors++;
        $display("FAIL to_wait cyc %0d got busy=%b perr=%b exp 1/0", i, fu_busy, proto_err);
      end
      tick();
    end
    checks++;
    if (fu_busy !== 1'b0 || proto_err !== 1'b1) begin
      errors++;
      $display("FAIL to_abort got busy=%b perr=%b exp 0/1", fu_busy, proto_err);
    end
    fu_done = 1'b1;
    #1;
    checks++;
    if (grant !== 2'b00) begin
      errors++;
      $display("FAIL late_done_grant got %b exp 00", grant);
    end
    tick();
    fu_done = 1'b0;
    checks++;
    if (fu_busy !== 1'b0 || proto_err !== 1'b1 || issued_rob_idx !== 5'd9 || issue_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL late_done got busy=%b perr=%b idx=%0d cnt=%0d exp 0/1/9/%0d",
               fu_busy, proto_err, issued_rob_idx, issue_cnt, exp_cnt);
    end
    tick();
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL perr_sticky got %b exp 1", proto_err);
    end
  endtask

  initial begin
    test_reset();
    test_oldest_pick();
    test_back_to_back();
    test_squash();
    test_ready_rise();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
